// File: rtl/apb_master_bridge_pkg.sv
// apb_master_pkg: shared FSM state type and register-file address map for the APB master bridge.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int unsigned REG_INTERNAL_STATUS = 0;
    localparam int unsigned REG_GO              = 1;
    localparam int unsigned REG_CENT_1          = 2;
    localparam int unsigned REG_CENT_2          = 3;
    localparam int unsigned REG_CENT_3          = 4;
    localparam int unsigned REG_CENT_4          = 5;
    localparam int unsigned REG_CENT_5          = 6;
    localparam int unsigned REG_CENT_6          = 7;
    localparam int unsigned REG_CENT_7          = 8;
    localparam int unsigned REG_CENT_8          = 9;
    localparam int unsigned REG_RAM_ADDR        = 10;
    localparam int unsigned REG_RAM_DATA        = 11;
    localparam int unsigned REG_FIRST_RAM_ADDR  = 12;
    localparam int unsigned REG_LAST_RAM_ADDR   = 13;

endpackage

// File: rtl/apb_master_bridge_timeout_cnt.sv
// apb_timeout_cnt: ACCESS wait counter; expired flags the last cycle a slave may still answer.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = cnt_q == LAST;

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single host commands into APB setup/access transfers
// with a bounded wait and a one-cycle completion pulse.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 91,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 penable,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
);

    state_e               state_q, state_d;
    logic [addrWidth-1:0] paddr_q, paddr_d;
    logic [dataWidth-1:0] pwdata_q, pwdata_d;
    logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 pwrite_q, pwrite_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 expired;

    apb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == SETUP),
        .enable (state_q == ACCESS && !pready),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // pready is checked first so a late answer beats the timeout
                if (pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if (expired) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        psel_d    = state_d != IDLE;
        penable_d = state_d == ACCESS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and randomized APB transfers checked against a transaction-level model.
module tb_apb_master_bridge;
    import apb_master_pkg::*;

    localparam int AW = 8;
    localparam int DW = 91;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;

    int checks = 0;
    int passed = 0;
    int rsp_cnt = 0;
    logic [DW-1:0] last_rd = '0;
    logic          last_err = 1'b0;

    apb_master_bridge #(
        .addrWidth(AW),
        .dataWidth(DW),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rsp_valid) rsp_cnt++;

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // One complete transfer: the slave answers after `delay` waited ACCESS cycles.
    // Starts at a negedge with the bridge idle, ends at the negedge of the response cycle.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int delay, input logic [DW-1:0] rd, input bit poke);
        int acc;
        int exp_acc;
        logic exp_err;
        logic [DW-1:0] exp_rd;
        exp_err = delay >= TO;
        exp_acc = exp_err ? TO : delay + 1;
        exp_rd  = (wr || exp_err) ? '0 : rd;
        prdata = rd;
        pready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_wdata = wd;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_before_accept got %b exp 1", cmd_ready); else passed++;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr = ~addr;
        cmd_wdata = ~wd;
        checks++; if ({psel, penable, cmd_ready} !== 3'b100) $display("FAIL setup_phase got psel/penable/ready=%b exp 100", {psel, penable, cmd_ready}); else passed++;
        checks++; if ({paddr, pwrite, pwdata} !== {addr, wr, wd}) $display("FAIL setup_capture got %h/%b/%h exp %h/%b/%h", paddr, pwrite, pwdata, addr, wr, wd); else passed++;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, last_err, last_rd}) $display("FAIL rsp_hold got v=%b e=%b d=%h exp v=0 e=%b d=%h", rsp_valid, rsp_err, rsp_rdata, last_err, last_rd); else passed++;
        @(negedge clk);
        acc = 0;
        while (psel && penable && acc < TO + 4) begin
            acc++;
            checks++; if ({paddr, pwrite, pwdata} !== {addr, wr, wd}) $display("FAIL access_stable cycle %0d got %h/%b/%h exp %h/%b/%h", acc, paddr, pwrite, pwdata, addr, wr, wd); else passed++;
            pready = (acc > delay) ? 1'b1 : 1'b0;
            if (poke && acc == 1) begin
                cmd_valid = 1'b1;
                cmd_addr = 8'hEE;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        pready = 1'b0;
        checks++; if (acc !== exp_acc) $display("FAIL access_cycles got %0d exp %0d", acc, exp_acc); else passed++;
        checks++; if ({rsp_valid, psel, penable, cmd_ready} !== 4'b1001) $display("FAIL response_cycle got valid/psel/penable/ready=%b exp 1001", {rsp_valid, psel, penable, cmd_ready}); else passed++;
        checks++; if (rsp_err !== exp_err) $display("FAIL rsp_err got %b exp %b", rsp_err, exp_err); else passed++;
        checks++; if (rsp_rdata !== exp_rd) $display("FAIL rsp_rdata got %h exp %h", rsp_rdata, exp_rd); else passed++;
        checks++; if ({paddr, pwrite, pwdata} !== {addr, wr, wd}) $display("FAIL idle_hold got %h/%b/%h exp %h/%b/%h", paddr, pwrite, pwdata, addr, wr, wd); else passed++;
        last_rd = exp_rd;
        last_err = exp_err;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready); else passed++;
        checks++; if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) $display("FAIL reset_ctrl got %b exp 00000", {psel, penable, pwrite, rsp_valid, rsp_err}); else passed++;
        checks++; if ({paddr, pwdata, rsp_rdata} !== '0) $display("FAIL reset_data got %h/%h/%h exp 0", paddr, pwdata, rsp_rdata); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, AW'(REG_RAM_ADDR), DW'(1), 0, rand_data(), 1'b0);
        idle(2);
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, AW'(REG_INTERNAL_STATUS), rand_data(), 3, DW'(91'h5A), 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = rsp_cnt;
        run_txn(1'b1, AW'(REG_RAM_DATA), DW'(6), 0, rand_data(), 1'b0);
        run_txn(1'b1, AW'(REG_GO), DW'(1), 0, rand_data(), 1'b0);
        idle(2);
        checks++; if (rsp_cnt - c0 !== 2) $display("FAIL b2b_pulses got %0d exp 2", rsp_cnt - c0); else passed++;
    endtask

    task automatic test_timeout();
        run_txn(1'b0, AW'(REG_CENT_3), rand_data(), TO + 5, rand_data(), 1'b0);
        idle(1);
        run_txn(1'b0, AW'(REG_CENT_4), rand_data(), TO - 1, rand_data(), 1'b0);
        idle(1);
        run_txn(1'b0, AW'(REG_CENT_5), rand_data(), TO, rand_data(), 1'b0);
        idle(1);
    endtask

    task automatic test_ignore_cmd();
        int c0;
        c0 = rsp_cnt;
        run_txn(1'b0, AW'(REG_CENT_1), rand_data(), 2, rand_data(), 1'b1);
        idle(3);
        checks++; if (rsp_cnt - c0 !== 1) $display("FAIL ignore_pulses got %0d exp 1", rsp_cnt - c0); else passed++;
        checks++; if ({psel, cmd_ready} !== 2'b01) $display("FAIL ignore_idle got psel/ready=%b exp 01", {psel, cmd_ready}); else passed++;
    endtask

    task automatic test_reset_during_access();
        int c0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = AW'(REG_LAST_RAM_ADDR);
        cmd_wdata = rand_data();
        pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        idle(3);
        checks++; if ({psel, penable} !== 2'b11) $display("FAIL rst_pre_access got %b exp 11", {psel, penable}); else passed++;
        c0 = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) $display("FAIL rst_async got psel/penable/valid/ready=%b exp 0001", {psel, penable, rsp_valid, cmd_ready}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        checks++; if (rsp_cnt !== c0) $display("FAIL rst_no_rsp got %0d pulses exp 0", rsp_cnt - c0); else passed++;
        checks++; if ({psel, cmd_ready, paddr} !== {2'b01, AW'(0)}) $display("FAIL rst_after got psel/ready=%b paddr=%h exp 01/00", {psel, cmd_ready}, paddr); else passed++;
        last_rd = '0;
        last_err = 1'b0;
    endtask

    task automatic test_random();
        int c0;
        c0 = rsp_cnt;
        for (int i = 0; i < 30; i++) begin
            run_txn($urandom_range(0, 1) == 1, AW'($urandom_range(0, 13)), rand_data(),
                    $urandom_range(0, TO + 3), rand_data(), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);
        checks++; if (rsp_cnt - c0 !== 30) $display("FAIL random_pulses got %0d exp 30", rsp_cnt - c0); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_ignore_cmd();
        test_reset_during_access();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- addrWidth, 8, APB address width
- dataWidth, 91, APB data width
- TIMEOUT, 16, maximum ACCESS cycles before abort (>=1)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  bridge accepts a command this cycle
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  addrWidth  register address
- cmd_wdata  in  dataWidth  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  dataWidth  read data (0 for writes and aborts)
- rsp_err  out  1  transfer aborted by timeout; valid with rsp_valid
- paddr  out  addrWidth  APB address to register file
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  dataWidth  APB write data
- prdata  in  dataWidth  APB read data
- pready  in  1  APB slave ready

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-004 cmd_ready SHALL be 1 exactly when the state is IDLE.
REQ-005 A handshake (cmd_valid && cmd_ready at a clock edge) SHALL capture cmd_write, cmd_addr and cmd_wdata into paddr, pwrite and pwdata, and SHALL move the FSM to SETUP.
REQ-006 SETUP SHALL drive psel=1 and penable=0 for exactly one cycle, then move to ACCESS.
REQ-007 ACCESS SHALL drive psel=1 and penable=1 until pready=1 is sampled or the timeout fires.
REQ-008 paddr, pwrite and pwdata SHALL remain stable from SETUP through the final ACCESS cycle, and SHALL hold their last values in IDLE.
REQ-009 On pready=1 in ACCESS, the next cycle SHALL have the following values:
- state=IDLE, psel=0, penable=0
- rsp_valid=1, rsp_err=0
- rsp_rdata=prdata as sampled on that edge for reads, 0 for writes
REQ-010 Minimum latency SHALL be as follows:
- command accepted in cycle N
- SETUP in cycle N+1
- ACCESS in cycle N+2
- rsp_valid and cmd_ready=1 in cycle N+3
- a new command SHALL be acceptable in cycle N+3 (back-to-back)
REQ-011 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-012 If the counter reaches TIMEOUT-1 with pready=0, the next cycle SHALL have the following values:
- state=IDLE, psel=0, penable=0
- rsp_valid=1, rsp_err=1, rsp_rdata=0
REQ-013 If pready=1 arrives in the same cycle the timeout would fire, pready SHALL win and rsp_err SHALL be 0.
REQ-014 rsp_valid SHALL be high for exactly one cycle per accepted command, with no backpressure.
REQ-015 rsp_rdata and rsp_err SHALL hold their values until the next response.
REQ-016 cmd_valid while cmd_ready=0 SHALL be ignored without being queued.
REQ-017 All outputs except cmd_ready SHALL be registered.

Reset
REQ-018 While rst_n=0, outputs SHALL take these values asynchronously:
- state=IDLE, so cmd_ready=1
- psel=0, penable=0, pwrite=0
- paddr=0, pwdata=0
- rsp_valid=0, rsp_err=0, rsp_rdata=0
- wait counter=0
REQ-019 Reset asserted during SETUP or ACCESS SHALL abort the transfer with no response pulse, and psel and penable SHALL drop immediately.

Structure
REQ-020 Package apb_master_pkg SHALL hold:
- the state enum
- the register address constants: internal_status 0, go 1, cent_1..cent_8 2..9, RAM_addr 10, RAM_data 11, first_ram_addr 12, last_ram_addr 13
REQ-021 The wait counter SHALL be the sub-module apb_timeout_cnt, with inputs clear and enable, output expired, and parameter TIMEOUT.

Verification
REQ-022 Write, RAM_addr=10, data 1, pready tied 1: psel rises in N+1, penable in N+2; rsp_valid=1 and rsp_err=0 in N+3; paddr=10 and pwdata=1 throughout.
REQ-023 Read, address 0, pready delayed 3 ACCESS cycles, prdata=91'h5A: penable high 4 cycles, rsp_rdata=91'h5A, rsp_err=0.
REQ-024 Back-to-back writes: go=1 presented in N+3 right after RAM_data=6 -> second SETUP in N+4, no idle gap, two rsp_valid pulses.
REQ-025 pready held 0, TIMEOUT=16: ACCESS lasts 16 cycles, then rsp_err=1, rsp_rdata=0, psel=0.
REQ-026 rst_n pulled low during ACCESS of a write: psel and penable go 0 immediately, no rsp_valid, cmd_ready=1 after release.
REQ-027 cmd_valid pulsed during ACCESS: ignored, exactly one response generated.
